muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Iterative multiply/divide unit for the extended single-cycle CPU. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and holds the HI/LO registers that MFHI and MFLO read. It takes the same register-file operands A and B as the ALU and sits beside it. Its hi/lo outputs feed the writeback mux, and its busy output stalls the PC and pipeline until a result is ready.

Parameters:
WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled on a clk edge only when busy=0
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others NOP
A  input  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO source)
B  input  WIDTH  rt operand (divisor / multiplier)
busy  output  1  high while an operation is in flight; CPU stalls on it
done  output  1  one-cycle pulse when HI/LO are updated by mul/div/mt*
div_by_zero  output  1  one-cycle pulse coincident with done for DIV/DIVU with B=0
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. While rst=1, hi=0, lo=0, busy=0, done=0, div_by_zero=0, state=IDLE and the counter is 0.
- Reset mid-operation: the operation is aborted, HI/LO are cleared and no done pulse is produced.
- States: IDLE, MUL, DIV, FIX.
- IDLE:
  - start=1 with MULT/MULTU: latch the operands and go to MUL.
  - start=1 with DIV/DIVU and B≠0: latch the operands and go to DIV.
  - start=1 with DIV/DIVU and B=0: stay in IDLE, leave HI/LO unchanged, pulse done and div_by_zero on the next cycle.
  - start=1 with MTHI/MTLO: write A to hi or lo at that edge, stay in IDLE, pulse done on the next cycle. busy never rises.
  - start=1 with any other op: no effect.
- Operand preparation (signed ops):
  - Convert operands to magnitudes and record the result signs: product sign = A[31]^B[31]; quotient sign = A[31]^B[31]; remainder sign = A[31].
  - Unsigned ops use the raw operands with positive signs.
- MUL: shift-add over a 64-bit accumulator, one multiplier bit per cycle, WIDTH cycles.
- DIV: restoring division, one quotient bit per cycle, WIDTH cycles.
- The counter counts 0..WIDTH-1. On the final iteration the unit goes to FIX.
- FIX:
  - Apply two's-complement negation per the recorded signs.
  - Write hi/lo: mul gives {hi,lo} = 64-bit product; div gives lo = quotient, hi = remainder.
  - Assert done for one cycle and return to IDLE.
- Latency: let the acceptance edge be E0. busy=1 after E0. Iterations occur at E1..E32. FIX happens at E33. hi/lo are valid, done=1 and busy=0 after E33. A new start may be accepted at E34.
- busy is a registered output.
- start while busy=1 is ignored. Operand and op changes during busy are ignored because values are latched at acceptance.
- Rounding: signed quotient truncates toward zero; the remainder takes the dividend's sign.
- Overflow case −2^31 / −1: lo=0x80000000, hi=0. No flag is raised.
- hi/lo are held between operations. Only completed ops, MTHI and MTLO change them.

Decomposition:
- Shared package holds:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO.
  - state encodings: S_IDLE, S_MUL, S_DIV, S_FIX.
- One natural combinational sub-module: muldiv_signfix. It does conditional negation of a WIDTH-bit value and is used both for the magnitude conversion and in FIX.
- The control FSM, counter and datapath live in muldiv_unit.

Test Plan:
- MULT A=0xFFFFFFFD (−3), B=7 → after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high exactly 33 cycles; done one cycle.
- MULTU A=B=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; then MULT with the same operands → hi=0, lo=1.
- DIV A=0xFFFFFFF9 (−7), B=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU A=100, B=7 → lo=14, hi=2.
  - DIV A=0x80000000, B=0xFFFFFFFF → lo=0x80000000, hi=0.
- DIV with B=0 (hi/lo preloaded via MTHI 0x1234, MTLO 0x5678) → busy stays 0; next cycle done=1 and div_by_zero=1; hi=0x1234, lo=0x5678 unchanged.
- Start MULTU 5×6, then assert start with DIVU 9/3 at cycle 10 → second start ignored; final hi=0, lo=30; no second done.
- Start DIV 100/7, assert rst at cycle 15 → hi=lo=0 and busy=0 immediately (asynchronous); no done. After release, MULT 2×3 → lo=6.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

  // Operation codes presented on the op port.
  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  // Control FSM states.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10,
    S_FIX  = 2'b11
  } state_e;

  // Signed ops convert operands to magnitudes and fix the sign at the end.
  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negation; used for operand magnitudes and result sign fix-up.
module muldiv_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  // Negate when requested, pass through otherwise.
  always_comb begin
    if (neg) begin
      res = ~val + {{(W-1){1'b0}}, 1'b1};
    end else begin
      res = val;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers.
// MUL: shift-add, one multiplier bit per cycle. DIV: restoring, one quotient bit per cycle.
// Both share one 2*WIDTH accumulator: {upper, lower} = {partial product, multiplier}
// for MUL and {remainder, dividend/quotient} for DIV.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opb_q, opb_d;     // multiplicand (MUL) or divisor (DIV) magnitude
  logic                 neg_lo_q, neg_lo_d; // product / quotient sign
  logic                 neg_hi_q, neg_hi_d; // remainder sign
  logic                 is_div_q, is_div_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 dbz_q, dbz_d;

  op_e                  op_s;
  logic                 signed_s;
  logic                 a_neg_s;
  logic                 b_neg_s;
  logic [WIDTH-1:0]     a_mag_s;
  logic [WIDTH-1:0]     b_mag_s;
  logic [2*WIDTH-1:0]   prod_fix_s;
  logic [WIDTH-1:0]     quo_fix_s;
  logic [WIDTH-1:0]     rem_fix_s;
  logic [WIDTH:0]       mul_sum_s;
  logic [2*WIDTH-1:0]   mul_next_s;
  logic [WIDTH:0]       div_top_s;
  logic [WIDTH:0]       div_diff_s;
  logic [2*WIDTH-1:0]   div_next_s;

  assign op_s     = op_e'(op);
  assign signed_s = op_is_signed(op);
  assign a_neg_s  = signed_s & A[WIDTH-1];
  assign b_neg_s  = signed_s & B[WIDTH-1];

  muldiv_signfix #(.W(WIDTH)) u_mag_a (.val(A), .neg(a_neg_s), .res(a_mag_s));
  muldiv_signfix #(.W(WIDTH)) u_mag_b (.val(B), .neg(b_neg_s), .res(b_mag_s));

  muldiv_signfix #(.W(2*WIDTH)) u_fix_prod (.val(acc_q), .neg(neg_lo_q), .res(prod_fix_s));
  muldiv_signfix #(.W(WIDTH)) u_fix_quo (.val(acc_q[WIDTH-1:0]), .neg(neg_lo_q), .res(quo_fix_s));
  muldiv_signfix #(.W(WIDTH)) u_fix_rem (.val(acc_q[2*WIDTH-1:WIDTH]), .neg(neg_hi_q), .res(rem_fix_s));

  // One shift-add multiply step and one restoring divide step on the shared accumulator.
  always_comb begin
    mul_sum_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    mul_next_s = {mul_sum_s, acc_q[WIDTH-1:1]};
    div_top_s  = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff_s = div_top_s - {1'b0, opb_q};
    if (div_diff_s[WIDTH]) begin
      div_next_s = {div_top_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      div_next_s = {div_diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
  end

  // Next-state, counter and datapath control.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    is_div_d = is_div_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op_s)
            OP_MULT, OP_MULTU: begin
              acc_d    = {{WIDTH{1'b0}}, b_mag_s};
              opb_d    = a_mag_s;
              neg_lo_d = a_neg_s ^ b_neg_s;
              neg_hi_d = a_neg_s ^ b_neg_s;
              is_div_d = 1'b0;
              cnt_d    = '0;
              busy_d   = 1'b1;
              state_d  = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
              if (B == {WIDTH{1'b0}}) begin
                done_d = 1'b1;
                dbz_d  = 1'b1;
              end else begin
                acc_d    = {{WIDTH{1'b0}}, a_mag_s};
                opb_d    = b_mag_s;
                neg_lo_d = a_neg_s ^ b_neg_s;
                neg_hi_d = a_neg_s;
                is_div_d = 1'b1;
                cnt_d    = '0;
                busy_d   = 1'b1;
                state_d  = S_DIV;
              end
            end
            OP_MTHI: begin
              hi_d   = A;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = A;
              done_d = 1'b1;
            end
            default: begin
              state_d = S_IDLE;
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        acc_d = mul_next_s;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_FIX;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = S_MUL;
        end
      end
      S_DIV: begin
        acc_d = div_next_s;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_FIX;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = S_DIV;
        end
      end
      S_FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix_s;
          lo_d = quo_fix_s;
        end else begin
          hi_d = prod_fix_s[2*WIDTH-1:WIDTH];
          lo_d = prod_fix_s[WIDTH-1:0];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any operation and clears HI/LO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      is_div_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      is_div_q <= is_div_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, corner sequences, random ops vs. model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        busy;
  logic        done;
  logic        dbz;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_vec = 0;
  int n_err = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(a_i), .B(b_i),
    .busy(busy), .done(done), .div_by_zero(dbz), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Issue one op and watch 36 cycles after the acceptance edge. Optionally poke a
  // second start (DIVU 9/3) at cycle poke_k, or pulse rst at cycle rst_k.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int poke_k, input int rst_k,
                        output int busy_n, output int done_n, output int done_k,
                        output int dbz_n, output int dbz_stray);
    busy_n = 0; done_n = 0; done_k = -1; dbz_n = 0; dbz_stray = 0;
    start = 1'b1; op = o; a_i = a; b_i = b;
    @(posedge clk); #1;
    for (int k = 1; k <= 36; k++) begin
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_k < 0) done_k = k;
      end
      if (dbz) begin
        dbz_n++;
        if (!done) dbz_stray++;
      end
      if (k == poke_k) begin
        start = 1'b1; op = 3'b011; a_i = 32'd9; b_i = 32'd3;
      end else begin
        start = 1'b0; op = 3'($urandom_range(0, 7)); a_i = $urandom; b_i = $urandom;
      end
      if (k == rst_k) begin
        rst = 1'b1;
        #1;
        check("async_rst.hi", 64'(hi), 64'h0);
        check("async_rst.lo", 64'(lo), 64'h0);
        check("async_rst.busy", 64'(busy), 64'h0);
      end else begin
        rst = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    rst = 1'b0;
  endtask

  // Run one op and check results plus timing derived from the op class.
  task automatic check_op(input string nm, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int busy_n, done_n, done_k, dbz_n, dbz_stray;
    bit is_md, is_dbz;
    int exp_busy, exp_done, exp_k;
    is_md    = (o <= 3'd3);
    is_dbz   = ((o == 3'd2) || (o == 3'd3)) && (b == 32'd0);
    exp_busy = (is_md && !is_dbz) ? 33 : 0;
    exp_done = (o <= 3'd5) ? 1 : 0;
    exp_k    = (exp_busy != 0) ? 34 : 1;
    run_op(o, a, b, 0, 0, busy_n, done_n, done_k, dbz_n, dbz_stray);
    check({nm, ".hi"}, 64'(hi), 64'(eh));
    check({nm, ".lo"}, 64'(lo), 64'(el));
    check({nm, ".busy_cycles"}, 64'(busy_n), 64'(exp_busy));
    check({nm, ".done_count"}, 64'(done_n), 64'(exp_done));
    if (exp_done != 0) check({nm, ".done_cycle"}, 64'(done_k), 64'(exp_k));
    check({nm, ".dbz_count"}, 64'(dbz_n), 64'(is_dbz ? 1 : 0));
    check({nm, ".dbz_without_done"}, 64'(dbz_stray), 64'h0);
  endtask

  // Reference model: architectural effect of one op on HI/LO.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       inout logic [31:0] mh, inout logic [31:0] ml);
    longint sa, sb;
    logic [63:0] p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd0: begin p = 64'(sa * sb); mh = p[63:32]; ml = p[31:0]; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; mh = p[63:32]; ml = p[31:0]; end
      3'd2: if (b != 32'd0) begin
              q = 64'(sa / sb); r = 64'(sa % sb); ml = q[31:0]; mh = r[31:0];
            end
      3'd3: if (b != 32'd0) begin ml = a / b; mh = a % b; end
      3'd4: mh = a;
      3'd5: ml = a;
      default: ;
    endcase
  endtask

  initial begin
    int busy_n, done_n, done_k, dbz_n, dbz_stray;
    logic [31:0] m_hi, m_lo, ra, rb;
    logic [2:0]  ro;

    tbl[0]  = '{3'd0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
    tbl[1]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    tbl[2]  = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    tbl[3]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[4]  = '{3'd3, 32'd100,      32'd7,        32'd2,        32'd14};
    tbl[5]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    tbl[6]  = '{3'd4, 32'h00001234, 32'hDEADBEEF, 32'h00001234, 32'h80000000};
    tbl[7]  = '{3'd5, 32'h00005678, 32'h0BADF00D, 32'h00001234, 32'h00005678};
    tbl[8]  = '{3'd2, 32'h00000055, 32'd0,        32'h00001234, 32'h00005678};
    tbl[9]  = '{3'd3, 32'hFFFFFFFF, 32'd0,        32'h00001234, 32'h00005678};
    tbl[10] = '{3'd7, 32'h11111111, 32'h22222222, 32'h00001234, 32'h00005678};
    tbl[11] = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    tbl[12] = '{3'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};

    rst = 1'b1; start = 1'b0; op = 3'd0; a_i = 32'd0; b_i = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.hi", 64'(hi), 64'h0);
    check("reset.lo", 64'(lo), 64'h0);
    check("reset.busy", 64'(busy), 64'h0);
    check("reset.done", 64'(done), 64'h0);
    check("reset.dbz", 64'(dbz), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      check_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo);
    end

    // Second start while busy must be ignored.
    run_op(3'd1, 32'd5, 32'd6, 10, 0, busy_n, done_n, done_k, dbz_n, dbz_stray);
    check("busy_start.hi", 64'(hi), 64'h0);
    check("busy_start.lo", 64'(lo), 64'd30);
    check("busy_start.busy_cycles", 64'(busy_n), 64'd33);
    check("busy_start.done_count", 64'(done_n), 64'd1);
    check("busy_start.idle_after", 64'(busy), 64'h0);

    // Reset mid-division aborts without done and clears HI/LO.
    run_op(3'd2, 32'd100, 32'd7, 0, 15, busy_n, done_n, done_k, dbz_n, dbz_stray);
    check("mid_rst.done_count", 64'(done_n), 64'd0);
    check("mid_rst.hi", 64'(hi), 64'h0);
    check("mid_rst.lo", 64'(lo), 64'h0);
    check("mid_rst.busy", 64'(busy), 64'h0);
    check_op("after_rst_mult", 3'd0, 32'd2, 32'd3, 32'd0, 32'd6);

    // Random ops against the reference model.
    m_hi = 32'd0; m_lo = 32'd6;
    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: ra = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      model(ro, ra, rb, m_hi, m_lo);
      check_op($sformatf("rnd%0d_op%0d", i, ro), ro, ra, rb, m_hi, m_lo);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
